// File: rtl/pixseq_pkg.sv
// Shared types and helpers for the pixel readout sequencer.
package pixseq_pkg;

    localparam int SYNC_LAT = 2;
    localparam int MAX_PIX  = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_INT  = 3'd2,
        ST_SMP  = 3'd3,
        ST_CONV = 3'd4,
        ST_OUT  = 3'd5,
        ST_NEXT = 3'd6
    } state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } bitsel_t;

    // Lowest set bit above cur; optionally wraps to the lowest set bit overall.
    function automatic bitsel_t next_set_bit(input logic [MAX_PIX-1:0] mask,
                                             input logic [4:0]         cur,
                                             input logic               wrap);
        bitsel_t r;
        r = '0;
        for (int i = MAX_PIX - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.idx   = 5'(i);
            end
        end
        if (!r.found && wrap) begin
            for (int i = MAX_PIX - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    r.found = 1'b1;
                    r.idx   = 5'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pixseq_sync2.sv
// Resettable two-flop synchroniser for asynchronous analog returns.
module pixseq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/pixel_readout_seq.sv
// Pixel array sequencer: reset/integrate/sample phases, single-slope ramp
// conversion per enabled channel, results over a valid/ready handshake.
module pixel_readout_seq
    import pixseq_pkg::*;
#(
    parameter int N_PIX = 12,
    parameter int CNT_W = 10,
    parameter int T_W   = 8,
    parameter int CH_W  = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cont_mode,
    input  logic [N_PIX-1:0] sel_mask,
    input  logic [T_W-1:0]   t_rst,
    input  logic [T_W-1:0]   t_int,
    input  logic [T_W-1:0]   t_sh,
    input  logic             cmp_in,
    output logic             sh_rst,
    output logic             sw1,
    output logic             sh,
    output logic             sh_cmp,
    output logic             sw2,
    output logic [N_PIX-1:0] pix_sel,
    output logic [CNT_W-1:0] ramp_code,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_data,
    output logic [CH_W-1:0]  res_ch,
    output logic             res_ovf
);
    state_e             state_q, state_d;
    logic [T_W-1:0]     timer_q, timer_d;
    logic [T_W-1:0]     trst_q, trst_d, tint_q, tint_d, tsh_q, tsh_d;
    logic [N_PIX-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   ramp_q, ramp_d;
    logic [CNT_W-1:0]   rdata_q, rdata_d;
    logic [CH_W-1:0]    rch_q, rch_d;
    logic               rovf_q, rovf_d;
    logic [N_PIX-1:0]   psel_q, psel_d;
    logic               shrst_q, sw1_q, sh_q, shcmp_q, busy_q, rvld_q;
    logic               cmp_s;
    bitsel_t            sel;

    // Timer counts down to 0, so a phase lasts max(t,1) cycles.
    function automatic logic [T_W-1:0] dur(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    pixseq_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_s)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        trst_d  = trst_q;
        tint_d  = tint_q;
        tsh_d   = tsh_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        ramp_d  = ramp_q;
        rdata_d = rdata_q;
        rch_d   = rch_q;
        rovf_d  = rovf_q;
        sel     = '0;
        case (state_q)
            ST_IDLE: if (start && (sel_mask != '0)) begin
                mask_d  = sel_mask;
                trst_d  = t_rst;
                tint_d  = t_int;
                tsh_d   = t_sh;
                sel     = next_set_bit(MAX_PIX'(sel_mask), 5'd31, 1'b1);
                ch_d    = sel.idx[CH_W-1:0];
                timer_d = dur(t_rst);
                state_d = ST_RST;
            end
            ST_RST: if (timer_q == '0) begin
                timer_d = dur(tint_q);
                state_d = ST_INT;
            end else timer_d = timer_q - 1'b1;
            ST_INT: if (timer_q == '0) begin
                timer_d = dur(tsh_q);
                state_d = ST_SMP;
            end else timer_d = timer_q - 1'b1;
            ST_SMP: if (timer_q == '0) begin
                ramp_d  = '0;
                state_d = ST_CONV;
            end else timer_d = timer_q - 1'b1;
            ST_CONV: begin
                // Trip seen SYNC_LAT codes late; back the code off by that much.
                if (cmp_s) begin
                    rdata_d = (ramp_q >= CNT_W'(SYNC_LAT)) ? ramp_q - CNT_W'(SYNC_LAT) : '0;
                    rovf_d  = 1'b0;
                    rch_d   = ch_q;
                    state_d = ST_OUT;
                end else if (ramp_q == '1) begin
                    rdata_d = '1;
                    rovf_d  = 1'b1;
                    rch_d   = ch_q;
                    state_d = ST_OUT;
                end else ramp_d = ramp_q + 1'b1;
            end
            ST_OUT: if (res_ready) state_d = ST_NEXT;
            ST_NEXT: begin
                sel = next_set_bit(MAX_PIX'(mask_q), 5'(ch_q), cont_mode);
                if (sel.found) begin
                    ch_d    = sel.idx[CH_W-1:0];
                    timer_d = dur(trst_q);
                    state_d = ST_RST;
                end else state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
        if (state_d != ST_CONV) ramp_d = '0;
        if (state_d != ST_OUT) begin
            rdata_d = '0;
            rch_d   = '0;
            rovf_d  = 1'b0;
        end
        psel_d = (state_d inside {ST_RST, ST_INT, ST_SMP, ST_CONV, ST_OUT}) ?
                 (N_PIX'(1) << ch_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            trst_q  <= '0;
            tint_q  <= '0;
            tsh_q   <= '0;
            mask_q  <= '0;
            ch_q    <= '0;
            ramp_q  <= '0;
            rdata_q <= '0;
            rch_q   <= '0;
            rovf_q  <= 1'b0;
            psel_q  <= '0;
            shrst_q <= 1'b0;
            sw1_q   <= 1'b0;
            sh_q    <= 1'b0;
            shcmp_q <= 1'b0;
            busy_q  <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            trst_q  <= trst_d;
            tint_q  <= tint_d;
            tsh_q   <= tsh_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            ramp_q  <= ramp_d;
            rdata_q <= rdata_d;
            rch_q   <= rch_d;
            rovf_q  <= rovf_d;
            psel_q  <= psel_d;
            shrst_q <= (state_d == ST_RST);
            sw1_q   <= (state_d == ST_INT);
            sh_q    <= (state_d == ST_SMP);
            shcmp_q <= (state_d == ST_CONV);
            busy_q  <= (state_d != ST_IDLE);
            rvld_q  <= (state_d == ST_OUT);
        end
    end

    assign sh_rst    = shrst_q;
    assign sw1       = sw1_q;
    assign sh        = sh_q;
    assign sh_cmp    = shcmp_q;
    assign sw2       = shcmp_q;
    assign pix_sel   = psel_q;
    assign ramp_code = ramp_q;
    assign busy      = busy_q;
    assign res_valid = rvld_q;
    assign res_data  = rdata_q;
    assign res_ch    = rch_q;
    assign res_ovf   = rovf_q;
endmodule

// File: tb/tb_pixel_readout_seq.sv
// Bench for pixel_readout_seq: table-driven frames with a result scoreboard,
// plus hand sequences for backpressure, continuous mode, abort and reset.
module tb_pixel_readout_seq;
    localparam int N_PIX = 12, CNT_W = 10, T_W = 8, CH_W = 4;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic cont_mode = 1'b0, res_ready = 1'b1, cmp_in = 1'b0;
    logic [N_PIX-1:0] sel_mask = '0;
    logic [T_W-1:0]   t_rst = '0, t_int = '0, t_sh = '0;
    logic sh_rst, sw1, sh, sh_cmp, sw2, busy, res_valid, res_ovf;
    logic [N_PIX-1:0] pix_sel;
    logic [CNT_W-1:0] ramp_code, res_data;
    logic [CH_W-1:0]  res_ch;

    pixel_readout_seq #(.N_PIX(N_PIX), .CNT_W(CNT_W), .T_W(T_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
        .sel_mask(sel_mask), .t_rst(t_rst), .t_int(t_int), .t_sh(t_sh), .cmp_in(cmp_in),
        .sh_rst(sh_rst), .sw1(sw1), .sh(sh), .sh_cmp(sh_cmp), .sw2(sw2), .pix_sel(pix_sel),
        .ramp_code(ramp_code), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ch(res_ch), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] mask; logic [7:0] tr, ti, ts; int trip; } vec_t;
    typedef struct { logic [9:0] data; int ch; logic ovf; } exp_t;

    vec_t vecs[7];
    exp_t exp_q[$];
    int total = 0, bad = 0, nres = 0;
    int trip_mode = -1;            // >=0: trip at that ramp code, -1: never, -2: before CONV
    int exp_rst = 1, exp_int = 1, exp_sh = 1;
    bit chk_len = 1'b1;
    int c_rst = 0, c_int = 0, c_sh = 0;
    logic [63:0] all_out;

    assign all_out = 64'({sh_rst, sw1, sh, sh_cmp, sw2, busy, res_valid, res_ovf,
                          pix_sel, ramp_code, res_data, res_ch});

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Comparator model: trips when the ramp hits the chosen code.
    always @(negedge clk) begin
        if (sh_rst || !busy || res_valid) cmp_in = 1'b0;
        else if (trip_mode == -2 && sw1) cmp_in = 1'b1;
        else if (trip_mode >= 0 && sh_cmp && int'(ramp_code) == trip_mode) cmp_in = 1'b1;
    end

    // Scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 64'(res_ch), 64'hFFFF);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_ch", 64'(res_ch), 64'(e.ch));
                chk("res_ovf", 64'(res_ovf), 64'(e.ovf));
                chk("res_pixsel", 64'(pix_sel), 64'(12'd1 << e.ch));
            end
            nres++;
        end
    end

    // Phase lengths and mutual exclusion of the control pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ok;
            ok = (int'(sh_rst) + int'(sw1) + int'(sh) + int'(sh_cmp) <= 1) && (sw2 == sh_cmp);
            if (sh_rst || sw1 || sh || sh_cmp || res_valid) ok = ok && $onehot(pix_sel);
            else ok = ok && (pix_sel == '0);
            chk("phase_excl", 64'(ok), 64'd1);
        end
        if (!chk_len || !rst_n) begin
            c_rst = 0; c_int = 0; c_sh = 0;
        end else begin
            if (sh_rst) c_rst++; else if (c_rst != 0) begin chk("len_rst", 64'(c_rst), 64'(exp_rst)); c_rst = 0; end
            if (sw1)    c_int++; else if (c_int != 0) begin chk("len_int", 64'(c_int), 64'(exp_int)); c_int = 0; end
            if (sh)     c_sh++;  else if (c_sh != 0)  begin chk("len_sh", 64'(c_sh), 64'(exp_sh));   c_sh = 0;  end
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0: return sw1;
            1: return sh_cmp;
            default: return res_valid;
        endcase
    endfunction

    task automatic wait_for(input int w, input int limit);
        int k = 0;
        while (!sig(w) && k < limit) begin tick(1); k++; end
        chk($sformatf("wait_sig%0d", w), 64'(sig(w)), 64'd1);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin tick(1); k++; end
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic push_frame(input logic [11:0] m, input int trip);
        for (int i = 0; i < N_PIX; i++) begin
            if (m[i]) begin
                exp_t e;
                e.ch   = i;
                e.ovf  = (trip == -1);
                e.data = (trip >= 0) ? 10'(trip) : (trip == -1) ? 10'h3FF : 10'd0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic setup(input vec_t v);
        sel_mask = v.mask; t_rst = v.tr; t_int = v.ti; t_sh = v.ts; trip_mode = v.trip;
        exp_rst = (v.tr == 0) ? 1 : int'(v.tr);
        exp_int = (v.ti == 0) ? 1 : int'(v.ti);
        exp_sh  = (v.ts == 0) ? 1 : int'(v.ts);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        setup(v);
        push_frame(v.mask, v.trip);
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_idle(6000);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n0, unstable;
        logic [9:0] d0;
        vecs[0] = '{12'h001, 8'd3, 8'd5, 8'd2, 100};
        vecs[1] = '{12'h824, 8'd1, 8'd2, 8'd1, 7};
        vecs[2] = '{12'h001, 8'd0, 8'd0, 8'd0, -1};
        vecs[3] = '{12'h010, 8'd2, 8'd1, 8'd3, -2};
        vecs[4] = '{12'h0F0, 8'd1, 8'd1, 8'd1, 2};
        vecs[5] = '{12'h800, 8'd4, 8'd0, 8'd1, 1};
        vecs[6] = '{12'h003, 8'd1, 8'd1, 8'd1, 0};

        tick(3);
        chk("reset_outs", all_out, 64'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_outs", all_out, 64'd0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Backpressure: result must hold while ready is low.
        setup('{12'h824, 8'd1, 8'd1, 8'd1, 7});
        push_frame(12'h824, 7);
        res_ready = 1'b0;
        pulse_start();
        wait_for(2, 500);
        d0 = res_data;
        chk("bp_data", 64'(d0), 64'd7);
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (res_data != d0 || ramp_code != '0 || !res_valid) unstable++;
        end
        chk("bp_stable", 64'(unstable), 64'd0);
        res_ready = 1'b1;
        wait_idle(2000);
        chk("bp_drain", 64'(exp_q.size()), 64'd0);

        // Ignored starts: empty mask, start+abort in IDLE, start while busy.
        sel_mask = '0; pulse_start(); tick(2);
        chk("start_mask0", 64'(busy), 64'd0);
        sel_mask = 12'h001; abort = 1'b1; pulse_start(); abort = 1'b0; tick(2);
        chk("start_abort", 64'(busy), 64'd0);
        setup('{12'h001, 8'd2, 8'd2, 8'd2, 20});
        push_frame(12'h001, 20);
        n0 = nres;
        pulse_start();
        wait_for(1, 200);
        sel_mask = 12'h800; t_rst = 8'd9;
        pulse_start();
        wait_idle(2000);
        chk("busy_start_nres", 64'(nres - n0), 64'd1);
        chk("busy_start_drain", 64'(exp_q.size()), 64'd0);

        // Continuous mode, then cleared during the third frame's ch0 conversion.
        setup('{12'h801, 8'd1, 8'd1, 8'd1, 5});
        for (int k = 0; k < 3; k++) push_frame(12'h801, 5);
        cont_mode = 1'b1;
        n0 = nres;
        pulse_start();
        for (int k = 0; k < 3000 && (nres - n0) < 4; k++) tick(1);
        chk("cont_four", 64'(nres - n0), 64'd4);
        wait_for(1, 200);
        cont_mode = 1'b0;
        wait_idle(3000);
        chk("cont_nres", 64'(nres - n0), 64'd6);
        chk("cont_drain", 64'(exp_q.size()), 64'd0);

        // Abort mid-INT: outputs clear next cycle, nothing emitted.
        chk_len = 1'b0;
        setup('{12'h001, 8'd2, 8'd6, 8'd2, -1});
        n0 = nres;
        pulse_start();
        wait_for(0, 100);
        tick(2);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("abort_outs", all_out, 64'd0);
        tick(3);
        chk("abort_idle", 64'(busy), 64'd0);
        chk_len = 1'b1;
        run_frame('{12'h004, 8'd1, 8'd2, 8'd1, 9});
        chk("abort_nres", 64'(nres - n0), 64'd1);

        // Asynchronous reset mid-CONV.
        chk_len = 1'b0;
        setup('{12'h002, 8'd1, 8'd1, 8'd1, -1});
        n0 = nres;
        pulse_start();
        wait_for(1, 100);
        tick(3);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", all_out, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("rst_idle", all_out, 64'd0);
        chk("rst_nres", 64'(nres - n0), 64'd0);
        chk_len = 1'b1;
        run_frame('{12'h002, 8'd1, 8'd1, 8'd1, 3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
